// File: rtl/mem_arbiter.sv
// Two-requester (instruction refill / data) arbiter in front of a single memory port.
// Optional build macro MEMARB_TIMEOUT_EN adds a per-transaction timeout with abort pulses.
module mem_arbiter #(
  parameter int N       = 64,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ireq,
  input  logic [31:0]  iadr,
  output logic [31:0]  irdata,
  output logic         ival,
  output logic         iabort,
  input  logic         dreq,
  input  logic [N-1:0] dadr,
  input  logic [N-1:0] dwdata,
  input  logic [1:0]   dwrite,
  output logic [N-1:0] drdata,
  output logic         dval,
  output logic         dabort,
  output logic         mreq,
  output logic [N-1:0] madr,
  output logic [N-1:0] mwdata,
  output logic [1:0]   mwrite,
  input  logic [N-1:0] mrdata,
  input  logic         mval,
  output logic [1:0]   grant
);

  // State encoding doubles as the grant code, so grant is simply the state register.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10
  } state_t;

  state_t state;
  logic   last_d;  // 1 when the data side owned the most recent transaction

  assign grant = state;

`ifdef MEMARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt;
`else
  assign iabort = 1'b0;
  assign dabort = 1'b0;
`endif

  // NOTE: all state below is written with non-blocking assignments so every
  // register samples the pre-edge values of the others, regardless of order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the data/address registers are reset too, because every output
      // of this block must read 0 while reset is held.
      state  <= IDLE;
      last_d <= 1'b0;
      mreq   <= 1'b0;
      madr   <= '0;
      mwdata <= '0;
      mwrite <= 2'b00;
      irdata <= '0;
      drdata <= '0;
      ival   <= 1'b0;
      dval   <= 1'b0;
`ifdef MEMARB_TIMEOUT_EN
      iabort <= 1'b0;
      dabort <= 1'b0;
      cnt    <= '0;
`endif
    end else begin
      ival <= 1'b0;
      dval <= 1'b0;
`ifdef MEMARB_TIMEOUT_EN
      iabort <= 1'b0;
      dabort <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // On a tie the side that did not win last time gets the port.
          if (dreq && (!ireq || !last_d)) begin
            state  <= BUSY_D;
            mreq   <= 1'b1;
            madr   <= dadr;
            mwdata <= dwdata;
            mwrite <= dwrite;
`ifdef MEMARB_TIMEOUT_EN
            cnt    <= '0;
`endif
          end else if (ireq) begin
            state  <= BUSY_I;
            mreq   <= 1'b1;
            madr   <= N'(iadr);
            mwdata <= '0;
            mwrite <= 2'b00;
`ifdef MEMARB_TIMEOUT_EN
            cnt    <= '0;
`endif
          end
        end

        BUSY_I, BUSY_D: begin
          // Completion takes priority over a timeout landing on the same edge.
          if (mval) begin
            state  <= IDLE;
            mreq   <= 1'b0;
            last_d <= (state == BUSY_D);
            if (state == BUSY_D) begin
              drdata <= mrdata;
              dval   <= 1'b1;
            end else begin
              irdata <= mrdata[31:0];
              ival   <= 1'b1;
            end
          end
`ifdef MEMARB_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT - 1)) begin
            state  <= IDLE;
            mreq   <= 1'b0;
            last_d <= (state == BUSY_D);
            if (state == BUSY_D) dabort <= 1'b1;
            else                 iabort <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
`endif
        end

        default: begin
          state <= IDLE;
          mreq  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transactions plus
// hand-written sequences for ties, reset during a transaction and the timeout.
module tb_mem_arbiter;

  localparam int N       = 64;
  localparam int TIMEOUT = 16;

  logic         clk;
  logic         reset;
  logic         ireq;
  logic [31:0]  iadr;
  logic [31:0]  irdata;
  logic         ival;
  logic         iabort;
  logic         dreq;
  logic [N-1:0] dadr;
  logic [N-1:0] dwdata;
  logic [1:0]   dwrite;
  logic [N-1:0] drdata;
  logic         dval;
  logic         dabort;
  logic         mreq;
  logic [N-1:0] madr;
  logic [N-1:0] mwdata;
  logic [1:0]   mwrite;
  logic [N-1:0] mrdata;
  logic         mval;
  logic [1:0]   grant;

  mem_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .reset  (reset),
    .ireq   (ireq),
    .iadr   (iadr),
    .irdata (irdata),
    .ival   (ival),
    .iabort (iabort),
    .dreq   (dreq),
    .dadr   (dadr),
    .dwdata (dwdata),
    .dwrite (dwrite),
    .drdata (drdata),
    .dval   (dval),
    .dabort (dabort),
    .mreq   (mreq),
    .madr   (madr),
    .mwdata (mwdata),
    .mwrite (mwrite),
    .mrdata (mrdata),
    .mval   (mval),
    .grant  (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected read-data registers, tracked by the bench from the vector table.
  logic [63:0] exp_ird;
  logic [63:0] exp_drd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        is_d;
    logic [31:0] iadr;
    logic [63:0] dadr;
    logic [63:0] dwdata;
    logic [1:0]  dwrite;
    logic [63:0] mrdata;
    int          delay;
    logic [63:0] exp_madr;
    logic [63:0] exp_mwdata;
    logic [1:0]  exp_mwrite;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input vec_t v);
    logic [1:0] g;
    g = v.is_d ? 2'b10 : 2'b01;
    check("idle_mreq", mreq, 0);
    check("idle_grant", grant, 0);
    if (v.is_d) begin
      dreq = 1'b1; dadr = v.dadr; dwdata = v.dwdata; dwrite = v.dwrite;
    end else begin
      ireq = 1'b1; iadr = v.iadr;
    end
    tick();
    check("grant", grant, g);
    check("mreq_on", mreq, 1);
    check("madr", madr, v.exp_madr);
    check("mwdata", mwdata, v.exp_mwdata);
    check("mwrite", mwrite, v.exp_mwrite);
    // Scramble requester inputs while busy; the memory side must not move.
    ireq = 1'b0; dreq = 1'b0;
    iadr = ~v.iadr; dadr = ~v.dadr; dwdata = ~v.dwdata; dwrite = ~v.dwrite;
    for (int d = 0; d < v.delay; d++) begin
      tick();
      check("busy_mreq", mreq, 1);
      check("busy_madr", madr, v.exp_madr);
      check("busy_mwdata", mwdata, v.exp_mwdata);
      check("busy_grant", grant, g);
    end
    mval = 1'b1; mrdata = v.mrdata;
    tick();
    mval = 1'b0; mrdata = '0;
    if (v.is_d) exp_drd = v.exp_rdata;
    else        exp_ird = v.exp_rdata;
    check("ival_pulse", ival, !v.is_d);
    check("dval_pulse", dval, v.is_d);
    check("irdata", irdata, exp_ird);
    check("drdata", drdata, exp_drd);
    check("done_mreq", mreq, 0);
    check("done_grant", grant, 0);
    tick();
    check("ival_end", ival, 0);
    check("dval_end", dval, 0);
    check("irdata_hold", irdata, exp_ird);
    check("drdata_hold", drdata, exp_drd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] tie_g[4];
    tie_g[0] = 2'b10; tie_g[1] = 2'b01; tie_g[2] = 2'b10; tie_g[3] = 2'b01;

    vecs[0] = '{1'b0, 32'h0000_0040, 64'h0, 64'h0, 2'b00, 64'hCAFE_F00D_1234_5678, 3,
                64'h40, 64'h0, 2'b00, 64'h1234_5678};
    vecs[1] = '{1'b1, 32'h0, 64'h80, 64'hDEAD_BEEF, 2'b11, 64'h0000_1111_2222_3333, 2,
                64'h80, 64'hDEAD_BEEF, 2'b11, 64'h0000_1111_2222_3333};
    vecs[2] = '{1'b1, 32'h0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 2'b00, 64'hA5A5_5A5A_0F0F_F0F0, 0,
                64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 2'b00, 64'hA5A5_5A5A_0F0F_F0F0};
    vecs[3] = '{1'b0, 32'hFFFF_FFFC, 64'h0, 64'h0, 2'b00, 64'h8765_4321_0000_0001, 1,
                64'h0000_0000_FFFF_FFFC, 64'h0, 2'b00, 64'h0000_0001};
    vecs[4] = '{1'b1, 32'h0, 64'h0123_4567_89AB_CDE0, 64'hFEDC_BA98_7654_3210, 2'b01,
                64'h0, 4, 64'h0123_4567_89AB_CDE0, 64'hFEDC_BA98_7654_3210, 2'b01, 64'h0};

    ireq = 0; dreq = 0; iadr = '0; dadr = '0; dwdata = '0; dwrite = '0;
    mrdata = '0; mval = 0;
    exp_ird = '0; exp_drd = '0;
    reset = 1'b0;
    #1;
    check("rst_mreq", mreq, 0);
    check("rst_grant", grant, 0);
    check("rst_madr", madr, 0);
    check("rst_irdata", irdata, 0);
    check("rst_drdata", drdata, 0);
    tick();
    reset = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // mval while idle must be ignored.
    mval = 1'b1; mrdata = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    mval = 1'b0; mrdata = '0;
    check("idle_mval_ival", ival, 0);
    check("idle_mval_dval", dval, 0);
    check("idle_mval_irdata", irdata, exp_ird);
    check("idle_mval_drdata", drdata, exp_drd);
    check("idle_mval_grant", grant, 0);

    // Reset in BUSY_D with mval pending.
    dreq = 1'b1; dadr = 64'h100; dwdata = 64'h77; dwrite = 2'b01;
    tick();
    check("rb_grant", grant, 2'b10);
    check("rb_mreq", mreq, 1);
    dreq = 1'b0; mval = 1'b1; mrdata = 64'h5555_5555;
    #2;
    reset = 1'b0;
    #1;
    check("rb_async_mreq", mreq, 0);
    check("rb_async_grant", grant, 0);
    check("rb_async_madr", madr, 0);
    check("rb_async_drdata", drdata, 0);
    exp_ird = '0; exp_drd = '0;
    tick();
    reset = 1'b1;
    tick();
    mval = 1'b0; mrdata = '0;
    check("rb_no_dval", dval, 0);
    check("rb_idle_grant", grant, 0);
    check("rb_idle_mreq", mreq, 0);
    check("rb_drdata", drdata, 0);

    // Both requests held from reset: D, I, D, I with an idle cycle between.
    reset = 1'b0;
    ireq = 1'b1; iadr = 32'h200; dreq = 1'b1; dadr = 64'h300; dwdata = '0; dwrite = 2'b00;
    tick();
    reset = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      check("tie_grant", grant, tie_g[k]);
      check("tie_mreq", mreq, 1);
      mval = 1'b1; mrdata = 64'(k + 1);
      tick();
      mval = 1'b0; mrdata = '0;
      check("tie_gap_grant", grant, 0);
      check("tie_gap_val", tie_g[k] == 2'b10 ? dval : ival, 1);
      if (k == 3) begin
        ireq = 1'b0; dreq = 1'b0;
      end
      tick();
    end
    check("tie_end_grant", grant, 0);
    check("tie_irdata", irdata, 64'h4);
    check("tie_drdata", drdata, 64'h3);

`ifdef MEMARB_TIMEOUT_EN
    // No mval: abort after TIMEOUT busy cycles.
    dreq = 1'b1; dadr = 64'h400; dwdata = '0; dwrite = 2'b00;
    tick();
    dreq = 1'b0;
    check("to_grant", grant, 2'b10);
    for (int c = 1; c < TIMEOUT; c++) begin
      tick();
      check("to_busy", {mreq, dabort}, 2'b10);
    end
    tick();
    check("to_dabort", dabort, 1);
    check("to_mreq", mreq, 0);
    check("to_grant_idle", grant, 0);
    check("to_dval", dval, 0);
    tick();
    check("to_dabort_end", dabort, 0);
    // mval in the last allowed cycle wins over the timeout.
    dreq = 1'b1;
    tick();
    dreq = 1'b0;
    for (int c = 1; c < TIMEOUT; c++) tick();
    mval = 1'b1; mrdata = 64'h99;
    tick();
    mval = 1'b0; mrdata = '0;
    check("tw_dval", dval, 1);
    check("tw_dabort", dabort, 0);
    check("tw_drdata", drdata, 64'h99);
    check("tw_grant", grant, 0);
`else
    // Without the timeout the arbiter waits indefinitely and never aborts.
    dreq = 1'b1; dadr = 64'h400; dwdata = '0; dwrite = 2'b00;
    tick();
    dreq = 1'b0;
    for (int c = 0; c < 3 * TIMEOUT; c++) tick();
    check("wait_mreq", mreq, 1);
    check("wait_grant", grant, 2'b10);
    check("wait_dabort", dabort, 0);
    check("wait_iabort", iabort, 0);
    mval = 1'b1; mrdata = 64'h99;
    tick();
    mval = 1'b0; mrdata = '0;
    check("wait_dval", dval, 1);
    check("wait_drdata", drdata, 64'h99);
    check("wait_grant_idle", grant, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter N, default 64, the data and memory-address width.
REQ-002 SHALL have parameter TIMEOUT, default 16, the cycles allowed per memory transaction (used only when MEMARB_TIMEOUT_EN is defined).
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 ireq  in  1  instruction-refill request (icache side), level.
REQ-006 iadr  in  32  instruction refill address.
REQ-007 irdata  out  32  instruction read data.
REQ-008 ival  out  1  instruction response valid, one-cycle pulse.
REQ-009 iabort  out  1  instruction transaction aborted, one-cycle pulse.
REQ-010 dreq  in  1  data request (datapath/dcache side), level.
REQ-011 dadr  in  N  data address.
REQ-012 dwdata  in  N  data write data.
REQ-013 dwrite  in  2  write-size code; 0 = read, same encoding as memwrite.
REQ-014 drdata  out  N  data read data.
REQ-015 dval  out  1  data response valid, one-cycle pulse.
REQ-016 dabort  out  1  data transaction aborted, one-cycle pulse.
REQ-017 mreq  out  1  memory request to the shared memory port.
REQ-018 madr  out  N  memory address.
REQ-019 mwdata  out  N  memory write data.
REQ-020 mwrite  out  2  memory write-size code.
REQ-021 mrdata  in  N  memory read data.
REQ-022 mval  in  1  memory completion strobe.
REQ-023 grant  out  2  current owner: 00 none, 01 instruction, 10 data.

Function
REQ-024 SHALL implement FSM states IDLE, BUSY_I and BUSY_D.
REQ-025 IDLE: ireq only -> BUSY_I; dreq only -> BUSY_D; both -> the requester not granted last, where lastgrant resets to I so data wins the first tie.
REQ-026 On the grant edge SHALL register madr/mwdata/mwrite (instruction: zero-extended iadr, mwdata 0, mwrite 0) and assert mreq from the next cycle.
REQ-027 While BUSY, mreq=1 and madr/mwdata/mwrite SHALL stay stable; requester input changes, including req deassertion, SHALL be ignored.
REQ-028 When mval=1 in BUSY_x: latch mrdata (irdata = mrdata[31:0]), pulse ival/dval in the following cycle, drop mreq, go to IDLE, and update lastgrant.
REQ-029 Latency: req high at edge k -> mreq high in cycle k+1; mval in cycle m -> val high in cycle m+1.
REQ-030 irdata/drdata SHALL hold their last value until the next response to that requester.
REQ-031 mval while IDLE SHALL be ignored.
REQ-032 A requester SHALL drop req in its val/abort cycle; req sampled high in that cycle starts a new transaction.
REQ-033 grant SHALL reflect the state register (01 in BUSY_I, 10 in BUSY_D, 00 in IDLE).

Reset
REQ-034 reset low SHALL immediately force IDLE, lastgrant=I, and all outputs 0, including an in-flight mreq; a pending mval is discarded.
REQ-035 The first grant SHALL follow at the first rising edge after reset is released.

Configuration
REQ-036 With MEMARB_TIMEOUT_EN defined, a counter cleared on grant SHALL count BUSY cycles; on reaching TIMEOUT without mval it SHALL drop mreq, pulse iabort/dabort for the owner next cycle, go to IDLE and update lastgrant.
REQ-037 mval arriving on the same edge as the timeout SHALL win: normal completion, no abort.
REQ-038 Without MEMARB_TIMEOUT_EN, the arbiter SHALL wait indefinitely for mval, iabort/dabort SHALL be tied 0, and no counter SHALL be synthesized.

Verification
REQ-039 ireq, iadr=0x40, mval after 3 cycles with mrdata=0x...12345678 -> grant=01, madr=0x40, mwrite=0, ival one cycle, irdata=0x12345678.
REQ-040 dreq with dwrite=2'b11, dadr=0x80, dwdata=0xDEADBEEF -> madr=0x80, mwdata=0xDEADBEEF, mwrite=11, dval after mval.
REQ-041 ireq and dreq held high together from reset -> grants alternate D, I, D, I with one IDLE cycle between transactions.
REQ-042 reset asserted in BUSY_D with mval pending -> mreq=0 asynchronously, grant=00, no dval after release.
REQ-043 MEMARB_TIMEOUT_EN, TIMEOUT=16, mval never asserted -> dabort pulse, mreq low, grant returns to 00; mval arriving exactly at cycle 16 -> dval, no dabort.
